// File: rtl/ex_pkg.sv
// Shared definitions for the RV32I execute stage: alu opcodes, branch conditions,
// the EX/MEM output bundle and the operand forwarding selector.
package ex_pkg;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluXor  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluAnd  = 4'b0100;
    localparam logic [3:0] AluSll  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSra  = 4'b0111;
    localparam logic [3:0] AluSlt  = 4'b1000;
    localparam logic [3:0] AluSltu = 4'b1001;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    // MEM beats WB beats the register file; x0 is hard-wired to zero.
    function automatic logic [31:0] fwd_mux(
        input logic [4:0]  rs,
        input logic [31:0] rf_data,
        input logic        mem_en,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_data,
        input logic        wb_en,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data
    );
        logic [31:0] v;
        if (rs == 5'd0) begin
            v = '0;
        end else if (mem_en && (mem_rd == rs)) begin
            v = mem_data;
        end else if (wb_en && (wb_rd == rs)) begin
            v = wb_data;
        end else begin
            v = rf_data;
        end
        return v;
    endfunction

    function automatic logic branch_cond(
        input logic [2:0] funct3,
        input logic       eq,
        input logic       lt,
        input logic       ltu
    );
        logic t;
        case (funct3)
            F3Beq:   t = eq;
            F3Bne:   t = !eq;
            F3Blt:   t = lt;
            F3Bge:   t = !lt;
            F3Bltu:  t = ltu;
            F3Bgeu:  t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu.sv
// RV32I integer alu: result per opcode plus comparison flags on the raw operands,
// which the execute stage uses to resolve branches.
module alu
    import ex_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_alu_control,
    output logic [31:0] o_result,
    output logic        o_equal,
    output logic        o_less_than,
    output logic        o_less_than_unsigned
);

    logic [4:0] w_shamt;

    assign w_shamt              = i_b[4:0];
    assign o_equal              = (i_a == i_b);
    assign o_less_than          = ($signed(i_a) < $signed(i_b));
    assign o_less_than_unsigned = (i_a < i_b);

    always_comb begin
        o_result = '0;
        case (i_alu_control)
            AluAdd:  o_result = i_a + i_b;
            AluSub:  o_result = i_a - i_b;
            AluXor:  o_result = i_a ^ i_b;
            AluOr:   o_result = i_a | i_b;
            AluAnd:  o_result = i_a & i_b;
            AluSll:  o_result = i_a << w_shamt;
            AluSrl:  o_result = i_a >> w_shamt;
            AluSra:  o_result = $signed(i_a) >>> w_shamt;
            AluSlt:  o_result = {31'd0, o_less_than};
            AluSltu: o_result = {31'd0, o_less_than_unsigned};
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, alu, branch/jump resolution, a single-entry
// EX/MEM output buffer with valid/ready on both sides, and a registered PC redirect pulse.
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned RESET_PC_ALIGN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    input  logic [3:0]      in_alu_control,
    input  logic            in_src_a_pc,
    input  logic            in_src_b_imm,
    input  logic            in_branch,
    input  logic [2:0]      in_funct3,
    input  logic            in_jal,
    input  logic            in_jalr,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic            mem_fwd_en,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_en,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic ClearJalrBit0 = (RESET_PC_ALIGN != 0);

    logic [31:0] w_fwd_rs1;
    logic [31:0] w_fwd_rs2;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_alu_result;
    logic        w_eq;
    logic        w_lt;
    logic        w_ltu;
    logic [31:0] w_tgt_base;
    logic [31:0] w_tgt_sum;
    logic [31:0] w_target;
    logic [31:0] w_link;
    logic        w_is_jump;
    logic        w_taken;
    logic        w_accept;
    ex_mem_t     w_bundle;

    logic        r_out_valid;
    ex_mem_t     r_out;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;

    assign w_fwd_rs1 = fwd_mux(in_rs1, in_rs1_data, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                               wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    assign w_fwd_rs2 = fwd_mux(in_rs2, in_rs2_data, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                               wb_fwd_en, wb_fwd_rd, wb_fwd_data);

    assign w_op_a = in_src_a_pc  ? in_pc  : w_fwd_rs1;
    assign w_op_b = in_src_b_imm ? in_imm : w_fwd_rs2;

    alu u_alu (
        .i_a                  (w_op_a),
        .i_b                  (w_op_b),
        .i_alu_control        (in_alu_control),
        .o_result             (w_alu_result),
        .o_equal              (w_eq),
        .o_less_than          (w_lt),
        .o_less_than_unsigned (w_ltu)
    );

    // Target adder is separate from the alu so branches can compare and add in one cycle.
    assign w_tgt_base = in_jalr ? w_fwd_rs1 : in_pc;
    assign w_tgt_sum  = w_tgt_base + in_imm;
    assign w_target   = {w_tgt_sum[31:1], (in_jalr && ClearJalrBit0) ? 1'b0 : w_tgt_sum[0]};
    assign w_link     = in_pc + 32'd4;

    assign w_is_jump = in_jal || in_jalr;
    assign w_taken   = w_is_jump || (in_branch && branch_cond(in_funct3, w_eq, w_lt, w_ltu));

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_comb begin
        w_bundle            = '0;
        w_bundle.result     = w_is_jump ? w_link : w_alu_result;
        w_bundle.store_data = w_fwd_rs2;
        w_bundle.rd         = in_rd;
        w_bundle.reg_write  = in_reg_write;
        w_bundle.mem_read   = in_mem_read;
        w_bundle.mem_write  = in_mem_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid      <= 1'b0;
            r_out            <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_accept && w_taken;
            if (w_accept && w_taken) begin
                r_redirect_pc <= w_target;
            end
            // flush dominates; an accept refills the slot even while draining.
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out       <= w_bundle;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_result     = r_out.result;
    assign out_store_data = r_out.store_data;
    assign out_rd         = r_out.rd;
    assign out_reg_write  = r_out.reg_write;
    assign out_mem_read   = r_out.mem_read;
    assign out_mem_write  = r_out.mem_write;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I pipeline. Sits between the ID/EX decode bundle and the MEM stage.
- Selects and forwards operands, drives the alu module, and resolves branches and jumps from the alu flags.
- Registers results into a single-entry EX/MEM output buffer with valid/ready handshakes on both sides.
- Emits a one-cycle PC redirect for taken control transfers.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- RESET_PC_ALIGN, 1, 1 = clear bit 0 of JALR targets

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX bundle valid
- in_ready  out  1  stage can accept bundle
- in_pc  in  32  instruction PC
- in_rs1, in_rs2  in  5  source register indices
- in_rs1_data, in_rs2_data  in  32  register-file read data
- in_imm  in  32  sign-extended immediate
- in_rd  in  5  destination index
- in_alu_control  in  4  alu opcode (ex_pkg encoding)
- in_src_a_pc  in  1  operand A = PC (AUIPC)
- in_src_b_imm  in  1  operand B = imm
- in_branch  in  1  conditional branch
- in_funct3  in  3  branch condition
- in_jal, in_jalr  in  1  jump kinds
- in_reg_write, in_mem_read, in_mem_write  in  1  control passthrough
- mem_fwd_en  in  1  MEM stage writes a register
- mem_fwd_rd  in  5  MEM destination
- mem_fwd_data  in  32  MEM result
- wb_fwd_en  in  1  WB stage writes a register
- wb_fwd_rd  in  5  WB destination
- wb_fwd_data  in  32  WB result
- flush  in  1  squash stage contents
- out_valid  out  1  EX/MEM bundle valid
- out_ready  in  1  MEM accepts bundle
- out_result  out  32  ALU result, or PC+4 for jumps
- out_store_data  out  32  forwarded rs2 value
- out_rd  out  5  destination
- out_reg_write, out_mem_read, out_mem_write  out  1  control
- redirect_valid  out  1  one-cycle PC redirect pulse
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (rst_n low, async): all outputs and registers go to 0, including out_valid, redirect_valid and redirect_pc.
- in_ready = !out_valid || out_ready. This is combinational; the stage does not deassert it spuriously.
- Accept: in_valid && in_ready && !flush. On the next clock edge the output register loads and out_valid = 1. Latency is 1 cycle.
- Hold: out_valid && !out_ready keeps every output stable.
- Drain: out_valid && out_ready with no accept clears out_valid. Accept and drain in the same cycle replaces the entry, giving full throughput.
- flush: out_valid is cleared next edge. An input presented in the same cycle is discarded, and no redirect is generated for it. flush wins over every other event.
- Forwarding per source, priority MEM > WB > register file:
  - Forward when the fwd_en bit is set, the rd matches, and rd != 0.
  - x0 always reads 0 regardless of forwarded or register-file data.
- Operand A = in_src_a_pc ? in_pc : fwd_rs1. Operand B = in_src_b_imm ? in_imm : fwd_rs2. out_store_data = fwd_rs2.
- Branch condition from alu flags (equal, less_than, less_than_unsigned):
  - funct3 000 = eq, 001 = !eq, 100 = lt, 101 = !lt, 110 = ltu, 111 = !ltu.
  - 010 and 011 are never taken.
  - For branches the decoder sets in_alu_control to SUB.
- Targets use a dedicated adder, not the alu. All arithmetic is modulo 2^32 and wraps silently.
  - Branch/JAL target = in_pc + in_imm.
  - JALR target = (fwd_rs1 + in_imm) with bit 0 cleared when RESET_PC_ALIGN = 1.
- out_result = in_pc + 4 for in_jal or in_jalr, otherwise the alu result.
- redirect_valid is registered. It is high for exactly the one cycle after an accepted taken branch, JAL or JALR, and is independent of out_ready. redirect_pc is held until the next redirect.
- Load-use stalls are handled upstream. This stage forwards only what is presented to it.

Decomposition:
- ex_pkg holds:
  - alu opcode constants: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001
  - funct3 branch constants
  - the ex_mem_t packed struct for the output bundle
- Instantiate the existing alu module as the only sub-module.
- A fwd_mux function lives in ex_pkg.

Test Plan:
- ADD x3 with rs1 = 5, rs2 = 7, out_ready = 1 -> next cycle out_valid = 1, out_result = 12, out_rd = 3.
- rs1 = x1 from regfile 0x10, mem_fwd rd = 1 with data 0x20, wb_fwd rd = 1 with data 0x30 -> A = 0x20. With mem_fwd_rd = 0 and rs1 = x0 -> A = 0.
- BLT pc = 0x100, imm = 0x40, rs1 = 0xFFFFFFFF, rs2 = 1 -> redirect_valid pulses 1 cycle with redirect_pc = 0x140. The BLTU variant -> no redirect.
- JALR pc = 0x200, rs1 = 0x1001, imm = 4 -> redirect_pc = 0x1004, out_result = 0x204.
- out_ready held 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and outputs stable; releasing it drains and accepts back-to-back.
- flush asserted while a taken branch is presented -> out_valid = 0 and no redirect. rst_n asserted mid-hold -> all outputs 0 immediately.
